// File: rtl/uart_rx_pkg.sv
// Shared types and register map for the memory-mapped UART receiver.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam logic [1:0] UART_DATA   = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;

  localparam int ST_VALID      = 0;
  localparam int ST_FULL       = 1;
  localparam int ST_FRAME_ERR  = 2;
  localparam int ST_OVERRUN    = 3;
  localparam int ST_COUNT_FULL = 4;

  function automatic logic [31:0] pack_status(
    input logic count_full,
    input logic overrun,
    input logic frame_err,
    input logic full,
    input logic valid
  );
    logic [31:0] s;
    s                = '0;
    s[ST_COUNT_FULL] = count_full;
    s[ST_OVERRUN]    = overrun;
    s[ST_FRAME_ERR]  = frame_err;
    s[ST_FULL]       = full;
    s[ST_VALID]      = valid;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational head output and wrap-bit pointers.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_write;
  logic             do_read;

  assign count = wr_ptr_reg - rd_ptr_reg;
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  // A push into a full FIFO only lands when the head is leaving in the same cycle.
  assign do_write = push && (!full || pop);
  assign do_read  = pop && !empty;

  assign dout = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr_reg[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_write) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_read)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_mmio.sv
// 8N1 UART receiver with a receive FIFO and DATA/STATUS registers on the core bus.
module uart_rx_mmio
  import uart_rx_pkg::*;
#(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rxd,
  input  logic        sel,
  input  logic        rd,
  input  logic [1:0]  addr,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(CLK_DIV/2 - 1);
  localparam logic [CW-1:0] FULL_RELOAD = CW'(CLK_DIV - 1);

  logic [1:0]    sync_reg;
  logic          rxs;
  rx_state_t     state_reg;
  logic [CW-1:0] cnt_reg;
  logic [2:0]    bit_idx_reg;
  logic [7:0]    shift_reg;
  logic          overrun_reg;
  logic          frame_err_reg;

  logic          stop_done;
  logic          push;
  logic          frame_set;
  logic          overrun_set;
  logic          pop;
  logic          status_rd;
  logic [7:0]    head;
  logic          empty;
  logic          full;
  logic [FW:0]   count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], rxd};
    end
  end

  assign rxs = sync_reg[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!rxs) begin
            cnt_reg   <= HALF_RELOAD;
            state_reg <= START;
          end
        end
        START: begin
          if (cnt_reg == '0) begin
            if (rxs) begin
              state_reg <= IDLE;
            end else begin
              cnt_reg     <= FULL_RELOAD;
              bit_idx_reg <= '0;
              state_reg   <= DATA;
            end
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        DATA: begin
          if (cnt_reg == '0) begin
            shift_reg <= {rxs, shift_reg[7:1]};
            cnt_reg   <= FULL_RELOAD;
            if (bit_idx_reg == 3'd7) begin
              state_reg <= STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        STOP: begin
          // Re-arm at mid-stop so a following start bit is never missed.
          if (cnt_reg == '0) begin
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign stop_done   = (state_reg == STOP) && (cnt_reg == '0);
  assign push        = stop_done && rxs;
  assign frame_set   = stop_done && !rxs;
  assign pop         = sel && rd && (addr == UART_DATA) && !empty;
  assign status_rd   = sel && rd && (addr == UART_STATUS);
  assign overrun_set = push && full && !pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (shift_reg),
    .dout  (head),
    .empty (empty),
    .full  (full),
    .count (count)
  );

  // Set has priority over the read-to-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      if (overrun_set)    overrun_reg <= 1'b1;
      else if (status_rd) overrun_reg <= 1'b0;
      if (frame_set)      frame_err_reg <= 1'b1;
      else if (status_rd) frame_err_reg <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      UART_DATA: begin
        if (!empty) rdata[7:0] = head;
      end
      UART_STATUS: begin
        rdata = pack_status(count == (FW+1)'(FIFO_DEPTH), overrun_reg,
                            frame_err_reg, full, !empty);
      end
      default: rdata = '0;
    endcase
  end

  assign irq = !empty;

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed bench for uart_rx_mmio: serial driver, scoreboard of expected bytes, register reads.
module tb_uart_rx_mmio;
  import uart_rx_pkg::*;

  localparam int D     = 16;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        rxd;
  logic        sel;
  logic        rd;
  logic [1:0]  addr;
  logic [31:0] rdata;
  logic        irq;

  int          checks;
  int          failures;
  logic [7:0]  exp_q[$];
  logic [31:0] v;

  uart_rx_mmio #(
    .CLK_DIV    (D),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rxd   (rxd),
    .sel   (sel),
    .rd    (rd),
    .addr  (addr),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  // Drives start + 8 data bits, leaves the stop level on the line and returns at its start.
  task automatic send_bits(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    tick(D);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(D);
    end
    rxd = stop;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic expect_push);
    send_bits(b, 1'b1);
    tick(D);
    if (expect_push) exp_q.push_back(b);
    $display("sent frame 0x%02h", b);
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] val);
    sel  = 1'b1;
    rd   = 1'b1;
    addr = a;
    #1;
    val = rdata;
    $display("read addr=%0d rdata=0x%08h", a, val);
    @(posedge clk);
    #1;
    sel  = 1'b0;
    rd   = 1'b0;
    addr = '0;
  endtask

  task automatic read_data(input string tag);
    logic [31:0] exp;
    logic [31:0] got;
    exp = '0;
    if (exp_q.size() != 0) exp = {24'b0, exp_q.pop_front()};
    read_reg(UART_DATA, got);
    check(tag, got, exp);
  endtask

  task automatic read_status(input string tag, input logic [31:0] exp);
    logic [31:0] got;
    read_reg(UART_STATUS, got);
    check(tag, got, exp);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    rxd      = 1'b1;
    sel      = 1'b0;
    rd       = 1'b0;
    addr     = UART_STATUS;
    tick(3);
    check("reset_irq", {31'b0, irq}, 32'h0);
    check("reset_status", rdata, 32'h0);
    addr = UART_DATA;
    #1;
    check("reset_data", rdata, 32'h0);
    rst_n = 1'b1;
    tick(4);

    // 1: single frame, push latency and pop
    send_bits(8'hA5, 1'b1);
    tick(10);
    check("t1_irq_before", {31'b0, irq}, 32'h0);
    tick(1);
    check("t1_irq_after", {31'b0, irq}, 32'h1);
    tick(5);
    exp_q.push_back(8'hA5);
    read_data("t1_data");
    check("t1_irq_fall", {31'b0, irq}, 32'h0);

    // 2: back-to-back frames
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    tick(D);
    read_data("t2_data0");
    read_data("t2_data1");
    read_data("t2_data2");
    read_status("t2_status", 32'h0);

    // 3: glitch shorter than half a bit
    rxd = 1'b0;
    tick(6);
    rxd = 1'b1;
    tick(3 * D);
    check("t3_irq", {31'b0, irq}, 32'h0);
    read_status("t3_status", 32'h0);

    // 4: framing error
    send_bits(8'h55, 1'b0);
    tick(D);
    rxd = 1'b1;
    tick(3 * D);
    check("t4_irq", {31'b0, irq}, 32'h0);
    read_status("t4_status", 32'h1 << ST_FRAME_ERR);
    read_status("t4_status_clr", 32'h0);

    // 5: overrun on a full FIFO
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), i <= DEPTH);
    end
    tick(D);
    read_status("t5_status", (32'h1 << ST_COUNT_FULL) | (32'h1 << ST_OVERRUN) |
                             (32'h1 << ST_FULL) | (32'h1 << ST_VALID));
    for (int i = 0; i < 5; i++) begin
      read_data($sformatf("t5_data%0d", i));
    end
    read_status("t5_status_end", 32'h0);

    // 6: reset mid-frame at data bit 3
    rxd = 1'b0;
    tick(D);
    for (int i = 0; i < 4; i++) begin
      rxd = i[0];
      tick(D);
    end
    tick(D / 2);
    rst_n = 1'b0;
    rxd   = 1'b1;
    tick(3);
    check("t6_irq_in_reset", {31'b0, irq}, 32'h0);
    rst_n = 1'b1;
    tick(2 * D);
    send_frame(8'h7E, 1'b1);
    tick(D);
    read_status("t6_status", 32'h1 << ST_VALID);
    read_data("t6_data");
    read_status("t6_status_end", 32'h0);
    check("t6_queue_empty", exp_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
